// File: rtl/synth_bus_pkg.sv
// Shared constants, state encoding and address/data helpers for the channel register bus.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package synth_bus_pkg;

    localparam logic [15:0] CHANNEL_BASE   = 16'h0010;
    localparam logic [15:0] CHANNEL_STRIDE = 16'h0020;

    localparam logic [1:0] REG_INC0 = 2'd0;
    localparam logic [1:0] REG_INC1 = 2'd1;
    localparam logic [1:0] REG_INC2 = 2'd2;
    localparam logic [1:0] REG_GATE = 2'd3;

    localparam logic [7:0] GATE_ON   = 8'h01;
    localparam logic [7:0] GATE_OFF  = 8'h00;
    localparam logic       BUS_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ALLOC,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    // Register address of one byte within a channel's register window.
    function automatic logic [15:0] reg_addr(input logic [15:0] ch, input logic [1:0] off);
        return CHANNEL_BASE + CHANNEL_STRIDE * ch + {14'd0, off};
    endfunction

    // Byte written at a given offset: increment bytes little-endian, then the gate.
    function automatic logic [7:0] byte_data(input logic on, input logic [1:0] off,
                                             input logic [23:0] inc);
        logic [7:0] d;
        case (off)
            REG_INC0: d = inc[7:0];
            REG_INC1: d = inc[15:8];
            REG_INC2: d = inc[23:16];
            default:  d = on ? GATE_ON : GATE_OFF;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake, channel register bus and status signals of the voice allocator.
// Latency: none, wiring only.
// Backpressure: NoteReady gates note acceptance; the bus itself has no backpressure.
interface voice_allocator_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int KEY_WIDTH    = 7
);
    logic                    NoteValid;
    logic                    NoteReady;
    logic                    NoteOn;
    logic [KEY_WIDTH-1:0]    NoteKey;
    logic [23:0]             NoteIncrement;
    logic [15:0]             BusAddress;
    logic [7:0]              BusData;
    logic                    BusDataOe;
    logic                    BusReadWrite;
    logic                    BusClock;
    logic [NUM_CHANNELS-1:0] ActiveMask;
    logic                    Busy;

    modport master (
        input  NoteValid, NoteOn, NoteKey, NoteIncrement,
        output NoteReady, BusAddress, BusData, BusDataOe, BusReadWrite, BusClock,
               ActiveMask, Busy
    );

    modport slave (
        output NoteValid, NoteOn, NoteKey, NoteIncrement,
        input  NoteReady, BusAddress, BusData, BusDataOe, BusReadWrite, BusClock,
               ActiveMask, Busy
    );
endinterface

// File: rtl/voice_lru.sv
// Age ranking of channels; victim is the channel allocated longest ago.
// Latency: touch updates ranks at the next edge; victim is combinational from the ranks.
// Backpressure: none, accepts a touch every cycle.
module voice_lru #(
    parameter int NUM_CHANNELS = 2,
    parameter int CH_W         = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            touch_i,
    input  logic [CH_W-1:0] ch_i,
    output logic [CH_W-1:0] victim_o
);
    logic [CH_W-1:0] age_q [NUM_CHANNELS];
    logic [CH_W-1:0] age_d [NUM_CHANNELS];

    // Touched channel becomes youngest; channels younger than it age by one.
    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            age_d[i] = age_q[i];
            if (touch_i) begin
                if (CH_W'(i) == ch_i) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[ch_i]) begin
                    age_d[i] = age_q[i] + CH_W'(1);
                end
            end
        end
    end

    // Ranks are a permutation, so exactly one channel holds the oldest rank.
    always_comb begin
        victim_o = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (age_q[i] == CH_W'(NUM_CHANNELS - 1)) begin
                victim_o = CH_W'(i);
            end
        end
    end

    // Rank registers start as the identity permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                age_q[i] <= CH_W'(i);
            end
        end else begin
            age_q <= age_d;
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Allocates note events to channels and writes channel registers over the strobed byte bus.
// Latency: handshake to ready 13 cycles for note-on, 4 for matched note-off, 1 for unmatched.
// Backpressure: NoteReady low from the handshake until the write sequence completes.
module voice_allocator
    import synth_bus_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int KEY_WIDTH    = 7
) (
    input logic            clk,
    input logic            rst_n,
    voice_allocator_if.master bus
);
    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    state_t                  state_q;
    logic                    rdy_q;
    logic                    strobe_q;
    logic                    rw_q;
    logic                    oe_q;
    logic [15:0]             addr_q;
    logic [7:0]              data_q;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [KEY_WIDTH-1:0]    key_q [NUM_CHANNELS];
    logic                    on_q;
    logic [KEY_WIDTH-1:0]    key_in_q;
    logic [23:0]             inc_q;
    logic [CH_W-1:0]         ch_q;
    logic [1:0]              off_q;

    logic                    match_hit;
    logic [CH_W-1:0]         match_ch;
    logic                    free_hit;
    logic [CH_W-1:0]         free_ch;
    logic [CH_W-1:0]         victim;
    logic [CH_W-1:0]         ch_d;
    logic [1:0]              off_d;
    logic                    touch;

    // Retrigger match first, then lowest free channel, else the LRU victim.
    always_comb begin
        match_hit = 1'b0;
        match_ch  = '0;
        free_hit  = 1'b0;
        free_ch   = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (mask_q[i] && (key_q[i] == key_in_q) && !match_hit) begin
                match_hit = 1'b1;
                match_ch  = CH_W'(i);
            end
            if (!mask_q[i] && !free_hit) begin
                free_hit = 1'b1;
                free_ch  = CH_W'(i);
            end
        end
        if (match_hit)     ch_d = match_ch;
        else if (free_hit) ch_d = free_ch;
        else               ch_d = victim;
        off_d = on_q ? REG_INC0 : REG_GATE;
    end

    assign touch = (state_q == ST_ALLOC) && on_q;

    voice_lru #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_W         (CH_W)
    ) u_lru (
        .clk      (clk),
        .rst_n    (rst_n),
        .touch_i  (touch),
        .ch_i     (ch_d),
        .victim_o (victim)
    );

    // Event capture, allocation table update and per-byte bus sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rdy_q    <= 1'b1;
            strobe_q <= 1'b0;
            rw_q     <= 1'b0;
            oe_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            mask_q   <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) key_q[i] <= '0;
            on_q     <= 1'b0;
            key_in_q <= '0;
            inc_q    <= '0;
            ch_q     <= '0;
            off_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.NoteValid && rdy_q) begin
                        on_q     <= bus.NoteOn;
                        key_in_q <= bus.NoteKey;
                        inc_q    <= bus.NoteIncrement;
                        rdy_q    <= 1'b0;
                        state_q  <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (on_q || match_hit) begin
                        if (on_q) begin
                            mask_q[ch_d] <= 1'b1;
                            key_q[ch_d]  <= key_in_q;
                        end else begin
                            mask_q[ch_d] <= 1'b0;
                        end
                        ch_q    <= ch_d;
                        off_q   <= off_d;
                        addr_q  <= reg_addr(16'(ch_d), off_d);
                        data_q  <= byte_data(on_q, off_d, inc_q);
                        rw_q    <= BUS_WRITE;
                        oe_q    <= 1'b1;
                        state_q <= ST_SETUP;
                    end else begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    strobe_q <= 1'b1;
                    state_q  <= ST_STROBE;
                end
                ST_STROBE: begin
                    strobe_q <= 1'b0;
                    state_q  <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (off_q == REG_GATE) begin
                        rw_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        off_q   <= off_q + 2'd1;
                        addr_q  <= reg_addr(16'(ch_q), off_q + 2'd1);
                        data_q  <= byte_data(on_q, off_q + 2'd1, inc_q);
                        state_q <= ST_SETUP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.NoteReady    = rdy_q;
    assign bus.Busy         = ~rdy_q;
    assign bus.BusClock     = strobe_q;
    assign bus.BusReadWrite = rw_q;
    assign bus.BusDataOe    = oe_q;
    assign bus.BusAddress   = addr_q;
    assign bus.BusData      = data_q;
    assign bus.ActiveMask   = mask_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboarded bench: expected bus writes are queued with each event and checked per strobe.
// Latency: measured from the handshake edge to NoteReady high.
// Backpressure: events are only presented/advanced while NoteReady is observed high.
module tb_voice_allocator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_CHANNELS(2), .KEY_WIDTH(7)) vif ();

    voice_allocator #(.NUM_CHANNELS(2), .KEY_WIDTH(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (vif)
    );

    int          checks   = 0;
    int          failures = 0;
    int          strobes  = 0;
    logic [23:0] exp_q [$];
    logic [23:0] mon_e;
    logic        bc_prev  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every rising BusClock consumes one expected (address, data) pair.
    always @(negedge clk) begin
        if (vif.BusClock && !bc_prev) begin
            strobes++;
            chk("strobe_rw_oe", {30'd0, vif.BusReadWrite, vif.BusDataOe}, 32'd3);
            if (exp_q.size() == 0) begin
                chk("strobe_expected", 32'd0, 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_addr_data", {8'd0, vif.BusAddress, vif.BusData}, {8'd0, mon_e});
            end
        end
        bc_prev <= vif.BusClock;
    end

    task automatic push4(input logic [15:0] base, input logic [23:0] inc);
        exp_q.push_back({base,         inc[7:0]});
        exp_q.push_back({base + 16'd1, inc[15:8]});
        exp_q.push_back({base + 16'd2, inc[23:16]});
        exp_q.push_back({base + 16'd3, 8'h01});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vif.NoteValid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!vif.NoteReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!vif.NoteReady) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic on, input logic [6:0] key, input logic [23:0] inc,
                        output int lat);
        wait_ready();
        @(negedge clk);
        vif.NoteOn        = on;
        vif.NoteKey       = key;
        vif.NoteIncrement = inc;
        vif.NoteValid     = 1'b1;
        @(posedge clk);
        #1;
        vif.NoteValid = 1'b0;
        chk("busy_after_hs", {30'd0, vif.Busy, vif.NoteReady}, 32'd2);
        lat = 0;
        while (lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            if (vif.NoteReady) break;
        end
        if (!vif.NoteReady) lat = -1;
    endtask

    initial begin
        int lat;
        int s0;
        int hs;
        logic        ev_on  [4];
        logic [6:0]  ev_key [4];
        logic [23:0] ev_inc [4];

        vif.NoteValid     = 1'b0;
        vif.NoteOn        = 1'b0;
        vif.NoteKey       = '0;
        vif.NoteIncrement = '0;
        do_reset();

        // Reset state
        chk("rst_ready",  {31'd0, vif.NoteReady}, 32'd1);
        chk("rst_busy",   {31'd0, vif.Busy}, 32'd0);
        chk("rst_ctl",    {29'd0, vif.BusClock, vif.BusReadWrite, vif.BusDataOe}, 32'd0);
        chk("rst_bus",    {8'd0, vif.BusAddress, vif.BusData}, 32'd0);
        chk("rst_mask",   {30'd0, vif.ActiveMask}, 32'd0);

        // Test 1: reset asserted during the first strobe
        wait_ready();
        @(negedge clk);
        vif.NoteOn = 1'b1; vif.NoteKey = 7'd10; vif.NoteIncrement = 24'h777777;
        vif.NoteValid = 1'b1;
        exp_q.push_back({16'h0010, 8'h77});
        @(posedge clk);
        #1;
        vif.NoteValid = 1'b0;
        s0 = strobes;
        for (int n = 0; n < 20 && strobes == s0; n++) begin
            @(negedge clk);
            #1;
        end
        chk("t1_strobe_seen", strobes - s0, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t1_async_ctl",  {30'd0, vif.BusClock, vif.BusDataOe}, 32'd0);
        chk("t1_async_mask", {30'd0, vif.ActiveMask}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobes;
        repeat (20) @(negedge clk);
        #1;
        chk("t1_no_strobe", strobes - s0, 32'd0);
        chk("t1_ready",     {31'd0, vif.NoteReady}, 32'd1);

        // Test 4: retrigger reuses channel 0
        push4(16'h0010, 24'h000100);
        send(1'b1, 7'd60, 24'h000100, lat);
        push4(16'h0010, 24'h000200);
        send(1'b1, 7'd60, 24'h000200, lat);
        chk("t4_lat",  lat, 32'd13);
        chk("t4_mask", {30'd0, vif.ActiveMask}, 32'd1);

        do_reset();

        // Test 2: first note-on to channel 0
        push4(16'h0010, 24'h123456);
        send(1'b1, 7'd60, 24'h123456, lat);
        chk("t2_lat",  lat, 32'd13);
        chk("t2_mask", {30'd0, vif.ActiveMask}, 32'd1);
        chk("t2_idle_ctl", {30'd0, vif.BusReadWrite, vif.BusDataOe}, 32'd0);
        chk("t2_bus_hold", {8'd0, vif.BusAddress, vif.BusData}, {8'd0, 16'h0013, 8'h01});

        // Test 5: matched and unmatched note-off
        exp_q.push_back({16'h0013, 8'h00});
        send(1'b0, 7'd60, 24'h0, lat);
        chk("t5_off_lat",  lat, 32'd4);
        chk("t5_off_mask", {30'd0, vif.ActiveMask}, 32'd0);
        s0 = strobes;
        send(1'b0, 7'd99, 24'h0, lat);
        chk("t5_miss_lat",    lat, 32'd1);
        chk("t5_miss_strobe", strobes - s0, 32'd0);

        // Test 3: fill both channels, then steal the oldest
        push4(16'h0010, 24'h111111);
        send(1'b1, 7'd60, 24'h111111, lat);
        push4(16'h0030, 24'h222222);
        send(1'b1, 7'd64, 24'h222222, lat);
        chk("t3_mask_full", {30'd0, vif.ActiveMask}, 32'd3);
        push4(16'h0010, 24'h333333);
        send(1'b1, 7'd67, 24'h333333, lat);
        chk("t3_steal_lat", lat, 32'd13);
        chk("t3_mask_steal", {30'd0, vif.ActiveMask}, 32'd3);

        // Test 6: NoteValid held high across back-to-back events
        ev_on[0] = 1'b0; ev_key[0] = 7'd64; ev_inc[0] = 24'h0;
        ev_on[1] = 1'b0; ev_key[1] = 7'd67; ev_inc[1] = 24'h0;
        ev_on[2] = 1'b1; ev_key[2] = 7'd50; ev_inc[2] = 24'h0A0B0C;
        ev_on[3] = 1'b0; ev_key[3] = 7'd77; ev_inc[3] = 24'h0;
        wait_ready();
        s0 = strobes;
        hs = 0;
        @(negedge clk);
        vif.NoteOn = ev_on[0]; vif.NoteKey = ev_key[0]; vif.NoteIncrement = ev_inc[0];
        exp_q.push_back({16'h0033, 8'h00});
        vif.NoteValid = 1'b1;
        for (int cyc = 0; cyc < 200 && hs < 4; cyc++) begin
            @(negedge clk);
            if (vif.NoteReady) begin
                @(posedge clk);
                #1;
                hs++;
                if (hs < 4) begin
                    vif.NoteOn = ev_on[hs]; vif.NoteKey = ev_key[hs];
                    vif.NoteIncrement = ev_inc[hs];
                    if (hs == 1) exp_q.push_back({16'h0013, 8'h00});
                    if (hs == 2) push4(16'h0010, ev_inc[2]);
                end else begin
                    vif.NoteValid = 1'b0;
                end
            end
        end
        vif.NoteValid = 1'b0;
        chk("t6_handshakes", hs, 32'd4);
        wait_ready();
        repeat (3) @(negedge clk);
        #1;
        chk("t6_strobes", strobes - s0, 32'd6);
        chk("t6_mask",    {30'd0, vif.ActiveMask}, 32'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Bus master that turns a stream of note-on/note-off events into register writes on the shared byte bus.
- Allocates each note to one of NUM_CHANNELS waveform channels: a retriggered key reuses its channel, otherwise the lowest free channel is used, otherwise the least-recently-allocated channel is stolen.
- Sits between the note/event source and the channel bank, and is the only bus writer to channel registers.

Parameters:
- NUM_CHANNELS, 2: number of channels managed. Channel i base address = 16'h0010 + 16'h0020*i.
- KEY_WIDTH, 7: width of the note key identifier.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- NoteValid  in  1  event request.
- NoteReady  out  1  block can accept an event; transfer occurs when NoteValid && NoteReady at a rising edge.
- NoteOn  in  1  1 = note-on, 0 = note-off.
- NoteKey  in  KEY_WIDTH  key identifier.
- NoteIncrement  in  24  phase increment for a note-on; ignored for note-off.
- BusAddress  out  16  write address.
- BusData  out  8  write data.
- BusDataOe  out  1  BusData drive enable, used by the top-level tristate.
- BusReadWrite  out  1  1 = write.
- BusClock  out  1  bus strobe; the channel latches data on its rising edge.
- ActiveMask  out  NUM_CHANNELS  bit i set = channel i gated on.
- Busy  out  1  equals ~NoteReady.

Behaviour:
- Reset (asynchronous, takes effect mid-operation): state IDLE, NoteReady=1, BusClock=0, BusReadWrite=0, BusDataOe=0, BusAddress=0, BusData=0, ActiveMask=0, all stored keys=0, age[i]=i.
  - An in-progress write sequence is abandoned without completing its strobe.
- States: IDLE, ALLOC, SETUP, STROBE, HOLD.
- IDLE:
  - NoteReady=1.
  - On handshake, capture NoteOn, NoteKey and NoteIncrement, then go to ALLOC.
  - NoteReady=0 in every other state.
- ALLOC (1 cycle), decision and table update:
  - Note-on with key matching an active channel → that channel (retrigger).
  - Else note-on → lowest-index channel with ActiveMask=0.
  - Else note-on → channel with maximum age (steal).
  - Every note-on: set ActiveMask[ch]=1, store key[ch], refresh age (age[ch]=0; each channel with age < old age[ch] increments). Ages remain a permutation of 0..NUM_CHANNELS-1, so ties are impossible.
  - Note-off with key matching an active channel → clear ActiveMask[ch]; ages are not changed.
  - Note-off with no match → go directly to IDLE, no bus traffic.
  - Otherwise go to SETUP with byte index 0.
- Write sequence:
  - Note-on writes 4 bytes, offsets 0,1,2,3: NoteIncrement[7:0], [15:8], [23:16], then gate 8'h01.
  - Note-off writes 1 byte: offset 3, data 8'h00.
  - Address = base(ch) + offset.
- Per byte (3 cycles):
  - SETUP: address and data valid, BusReadWrite=1, BusDataOe=1, BusClock=0.
  - STROBE: BusClock=1.
  - HOLD: BusClock=0, address and data held.
  - After HOLD: next byte's SETUP, or IDLE after the last byte. On entering IDLE, BusReadWrite=0 and BusDataOe=0; BusAddress and BusData hold their last values.
- Latency from the handshake edge to NoteReady=1:
  - Note-on: 13 cycles.
  - Matched note-off: 4 cycles.
  - Unmatched note-off: 1 cycle.
- Simultaneous events: none are possible. Events are serialized by NoteReady; inputs are sampled only at the handshake.
- Multiple active channels holding the same key cannot occur, because a retrigger always reuses the existing channel.

Decomposition:
- Package synth_bus_pkg:
  - CHANNEL_BASE=16'h0010, CHANNEL_STRIDE=16'h0020.
  - Register offsets: REG_INC0=0, REG_INC1=1, REG_INC2=2, REG_GATE=3.
  - GATE_ON=8'h01, GATE_OFF=8'h00, BUS_WRITE=1'b1.
  - State enum.
- Sub-module voice_lru:
  - Holds the age ranks.
  - Inputs: touch strobe, channel index.
  - Output: victim index (maximum age).

Test Plan:
1. Reset low mid-STROBE → BusClock=0, BusDataOe=0 and ActiveMask=0 immediately (asynchronous); after release, NoteReady=1 and no further strobes occur.
2. Note-on key 60, increment 24'h123456, all channels free → four strobes with (BusAddress:BusData) 0010:56, 0011:34, 0012:12, 0013:01; ActiveMask=2'b01; NoteReady high again 13 cycles after the handshake.
3. Note-on key 60, then key 64, then key 67 (NUM_CHANNELS=2) → key 64 goes to channel 1 (0030..0033); key 67 steals channel 0 (0010..0013, gate 01); ActiveMask stays 2'b11.
4. Note-on key 60 twice with increments 24'h000100 and 24'h000200 → both sequences target channel 0 (second writes 0010:00, 0011:02, 0012:00, 0013:01); channel 1 is untouched.
5. Note-off key 60 after test 2 → single strobe 0013:00, ActiveMask=0, ready after 4 cycles. Note-off key 99 → no BusClock pulse, ready after 1 cycle.
6. NoteValid held high with back-to-back events → each event is accepted only when NoteReady=1; no event is lost or duplicated, which is checked by counting strobes against expected bytes.
